switch_input_port: RTL and testbench

//  Bus-side input peripheral: the inbound counterpart of the seven-segment output path.

---
 rtl/switch_input_port_if.sv | 28 ++
 rtl/switch_input_port.sv | 134 +++++++++++++
 tb/tb_switch_input_port.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_input_port_if.sv
// Bus-side read port of the switch input peripheral: strobes from the control unit,
// word and enable toward the shared-bus buffer, plus the pending-event interrupt.
interface switch_input_port_if;
    logic        data_rd;
    logic        stat_rd;
    logic        ovf_clr;
    logic [15:0] bus_data;
    logic        bus_oe;
    logic        irq;

    modport master (
        output data_rd,
        output stat_rd,
        output ovf_clr,
        input  bus_data,
        input  bus_oe,
        input  irq
    );

    modport slave (
        input  data_rd,
        input  stat_rd,
        input  ovf_clr,
        output bus_data,
        output bus_oe,
        output irq
    );
endinterface

// File: rtl/switch_input_port.sv
// Switch input peripheral: synchronise and debounce board switches, queue each committed
// change as a sequenced 16-bit event word, and serve events/status on the shared bus.
module switch_input_port #(
    parameter int unsigned SW_WIDTH        = 3,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [SW_WIDTH-1:0] stable_sw,
    switch_input_port_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SEQ_W  = 4;

    typedef enum logic {STABLE, SETTLING} db_state_t;

    logic [SW_WIDTH-1:0] sync_1, sync_q;
    db_state_t           state, state_d;
    logic [SW_WIDTH-1:0] cand, cand_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                commit;

    logic [15:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [FILL_W-1:0]   fill;
    logic [SEQ_W-1:0]    seq;
    logic                ovf;
    logic                empty, full, push, pop, drop;

    // Two-flop synchroniser on the asynchronous switch lines
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '0;
            sync_q <= '0;
        end else begin
            sync_1 <= sw_raw;
            sync_q <= sync_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STABLE;
            cand      <= '0;
            cnt       <= '0;
            stable_sw <= '0;
        end else begin
            state <= state_d;
            cand  <= cand_d;
            cnt   <= cnt_d;
            if (commit) stable_sw <= cand;
        end
    end

    // A return to the committed value rejects the glitch; a new value restarts the run
    always_comb begin
        state_d = state;
        cand_d  = cand;
        cnt_d   = cnt;
        commit  = 1'b0;
        case (state)
            STABLE: begin
                if (sync_q != stable_sw) begin
                    cand_d  = sync_q;
                    cnt_d   = CNT_W'(1);
                    state_d = SETTLING;
                end
            end
            SETTLING: begin
                if (sync_q == stable_sw) begin
                    state_d = STABLE;
                end else if (sync_q != cand) begin
                    cand_d = sync_q;
                    cnt_d  = CNT_W'(1);
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    commit  = 1'b1;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = STABLE;
        endcase
    end

    assign empty = (fill == '0);
    assign full  = (fill == FILL_W'(DEPTH));
    assign push  = commit;
    assign pop   = bus.data_rd && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push && !drop) mem[wr_ptr] <= {seq, 12'(cand)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            seq    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) seq <= seq + SEQ_W'(1);
            if (push && !drop) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !drop && !pop) fill <= fill + FILL_W'(1);
            else if (pop && !(push && !drop)) fill <= fill - FILL_W'(1);
            if (drop) ovf <= 1'b1;
            else if (bus.ovf_clr) ovf <= 1'b0;
        end
    end

    // Zero-latency read mux; data strobe has priority over status
    always_comb begin
        bus.bus_oe   = 1'b0;
        bus.bus_data = 16'h0000;
        if (!rst) begin
            bus.bus_oe = bus.data_rd | bus.stat_rd;
            if (bus.data_rd) begin
                bus.bus_data = empty ? 16'h0000 : mem[rd_ptr];
            end else if (bus.stat_rd) begin
                bus.bus_data = {ovf, empty, full, 5'b00000, 8'(fill)};
            end
        end
    end

    assign bus.irq = !rst && !empty;
endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port: directed scenarios plus randomized traffic
// compared against a run-length/queue reference model.
module tb_switch_input_port;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sw_raw = 3'b000;
    logic [2:0] stable_sw;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    switch_input_port_if bus_if();

    switch_input_port #(.SW_WIDTH(3), .DEPTH(4), .DEBOUNCE_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .stable_sw (stable_sw),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: a switch value commits once it has been seen for 16 consecutive
    // synchronised samples (sample = sw_raw two edges earlier) and differs from the committed value.
    logic [2:0]  d1, d2, prev_s, stable_m;
    int          run;
    logic [3:0]  seq_m;
    bit          ovf_m;
    logic [15:0] q[$];

    task automatic model_edge();
        logic [2:0] s;
        bit push, pop, drop;
        if (rst) begin
            d1 = 0; d2 = 0; prev_s = 0; run = 0; stable_m = 0; seq_m = 0; ovf_m = 0;
            q.delete();
            return;
        end
        s = d2; d2 = d1; d1 = sw_raw;
        if (s == prev_s) run++; else run = 1;
        prev_s = s;
        push = (s != stable_m) && (run >= 16);
        pop  = bus_if.data_rd && (q.size() != 0);
        drop = 0;
        if (pop) void'(q.pop_front());
        if (push) begin
            stable_m = s;
            if (q.size() < 4) q.push_back({seq_m, 9'd0, s});
            else drop = 1;
            seq_m++;
        end
        if (drop) ovf_m = 1;
        else if (bus_if.ovf_clr) ovf_m = 0;
    endtask

    function automatic logic [15:0] exp_data();
        if (rst) return 16'h0000;
        if (bus_if.data_rd) return (q.size() != 0) ? q[0] : 16'h0000;
        if (bus_if.stat_rd) return {ovf_m, q.size() == 0, q.size() == 4, 5'b00000, 8'(q.size())};
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic clear_strobes();
        bus_if.data_rd = 0; bus_if.stat_rd = 0; bus_if.ovf_clr = 0;
    endtask

    task automatic do_reset();
        rst = 1; sw_raw = 0; clear_strobes();
        tick(); tick();
        rst = 0;
    endtask

    task automatic hold_value(input logic [2:0] v, input int cycles);
        sw_raw = v;
        repeat (cycles) tick();
    endtask

    task automatic test_reset();
        rst = 1; sw_raw = 3'b111; clear_strobes();
        tick(); tick();
        bus_if.data_rd = 1; bus_if.stat_rd = 1;
        #1;
        total_cnt++;
        if ({bus_if.bus_oe, bus_if.bus_data, bus_if.irq, stable_sw} !== 21'd0) $display("FAIL reset_outputs: oe=%b data=%h irq=%b stable=%b, expected all 0", bus_if.bus_oe, bus_if.bus_data, bus_if.irq, stable_sw);
        else pass_cnt++;
        sw_raw = 0; clear_strobes();
        tick();
        rst = 0;
    endtask

    task automatic test_basic_commit();
        int t_stable = -1, t_irq = -1;
        do_reset();
        sw_raw = 3'b101;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (t_stable < 0 && stable_sw == 3'b101) t_stable = i;
            if (t_irq < 0 && bus_if.irq === 1'b1) t_irq = i;
        end
        total_cnt++;
        if (t_stable != 18) $display("FAIL commit_latency: stable_sw at edge %0d, expected 18", t_stable); else pass_cnt++;
        total_cnt++;
        if (t_irq != 18) $display("FAIL irq_latency: irq at edge %0d, expected 18", t_irq); else pass_cnt++;
        bus_if.data_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h0005 || bus_if.bus_oe !== 1'b1) $display("FAIL first_event: data=%h oe=%b, expected 0005 1", bus_if.bus_data, bus_if.bus_oe); else pass_cnt++;
        tick();
        bus_if.data_rd = 0;
        #1;
        total_cnt++;
        if (bus_if.irq !== 1'b0) $display("FAIL irq_after_pop: irq=%b, expected 0", bus_if.irq); else pass_cnt++;
    endtask

    task automatic test_glitch();
        hold_value(3'b000, 10);
        hold_value(3'b101, 30);
        bus_if.stat_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h4000 || bus_if.irq !== 1'b0 || stable_sw !== 3'b101) $display("FAIL glitch: status=%h irq=%b stable=%b, expected 4000 0 101", bus_if.bus_data, bus_if.irq, stable_sw); else pass_cnt++;
        tick();
        clear_strobes();
    endtask

    task automatic test_overflow();
        logic [2:0] vals [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        logic [15:0] want;
        do_reset();
        for (int k = 0; k < 5; k++) hold_value(vals[k], 20);
        bus_if.stat_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'hA004) $display("FAIL ovf_status: got %h, expected a004", bus_if.bus_data); else pass_cnt++;
        bus_if.stat_rd = 0;
        for (int k = 0; k < 4; k++) begin
            bus_if.data_rd = 1;
            #1;
            want = {4'(k), 9'd0, vals[k]};
            total_cnt++;
            if (bus_if.bus_data !== want) $display("FAIL pop_order[%0d]: got %h, expected %h", k, bus_if.bus_data, want); else pass_cnt++;
            tick();
        end
        bus_if.data_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h0000 || bus_if.bus_oe !== 1'b1) $display("FAIL pop_empty: data=%h oe=%b, expected 0000 1", bus_if.bus_data, bus_if.bus_oe); else pass_cnt++;
        tick();
        bus_if.data_rd = 0; bus_if.ovf_clr = 1;
        tick();
        bus_if.ovf_clr = 0; bus_if.stat_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h4000) $display("FAIL ovf_clear: got %h, expected 4000", bus_if.bus_data); else pass_cnt++;
        tick();
        clear_strobes();
    endtask

    task automatic test_full_commit_pop();
        logic [15:0] last;
        do_reset();
        for (int k = 1; k <= 4; k++) hold_value(3'(k), 20);
        sw_raw = 3'd7;
        repeat (17) tick();
        bus_if.data_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h0001) $display("FAIL full_head: got %h, expected 0001", bus_if.bus_data); else pass_cnt++;
        tick();
        bus_if.data_rd = 0; bus_if.stat_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h2004 || stable_sw !== 3'd7) $display("FAIL full_push_pop: status=%h stable=%b, expected 2004 111", bus_if.bus_data, stable_sw); else pass_cnt++;
        bus_if.stat_rd = 0; bus_if.data_rd = 1;
        repeat (3) begin #1; tick(); end
        #1;
        last = bus_if.bus_data;
        tick();
        clear_strobes();
        total_cnt++;
        if (last !== 16'h4007) $display("FAIL full_tail: got %h, expected 4007", last); else pass_cnt++;
    endtask

    task automatic test_both_strobes();
        do_reset();
        hold_value(3'd2, 20);
        hold_value(3'd3, 20);
        bus_if.data_rd = 1; bus_if.stat_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h0002 || bus_if.bus_oe !== 1'b1) $display("FAIL both_strobes: data=%h oe=%b, expected 0002 1", bus_if.bus_data, bus_if.bus_oe); else pass_cnt++;
        tick();
        bus_if.data_rd = 0;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h0001) $display("FAIL both_count: status=%h, expected 0001", bus_if.bus_data); else pass_cnt++;
        tick();
        clear_strobes();
    endtask

    task automatic test_reset_mid();
        int t_stable = -1;
        do_reset();
        hold_value(3'd1, 20);
        hold_value(3'd2, 20);
        sw_raw = 3'b101;
        repeat (9) tick();
        rst = 1;
        tick();
        rst = 0; bus_if.stat_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h4000 || bus_if.irq !== 1'b0 || stable_sw !== 3'd0) $display("FAIL reset_mid: status=%h irq=%b stable=%b, expected 4000 0 000", bus_if.bus_data, bus_if.irq, stable_sw); else pass_cnt++;
        bus_if.stat_rd = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (t_stable < 0 && stable_sw == 3'b101) t_stable = i;
        end
        total_cnt++;
        if (t_stable != 18) $display("FAIL reset_recommit: edge %0d, expected 18", t_stable); else pass_cnt++;
        bus_if.data_rd = 1;
        #1;
        total_cnt++;
        if (bus_if.bus_data !== 16'h0005) $display("FAIL reset_seq: got %h, expected 0005", bus_if.bus_data); else pass_cnt++;
        tick();
        clear_strobes();
    endtask

    task automatic test_random();
        logic [21:0] got, want;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) sw_raw = 3'($urandom);
            rst            = ($urandom_range(0, 599) == 0);
            bus_if.data_rd = ($urandom_range(0, 11) == 0);
            bus_if.stat_rd = ($urandom_range(0, 5) == 0);
            bus_if.ovf_clr = ($urandom_range(0, 39) == 0);
            #1;
            got  = {bus_if.bus_data, bus_if.bus_oe, bus_if.irq, stable_sw, 1'b0};
            want = {exp_data(), !rst && (bus_if.data_rd || bus_if.stat_rd), !rst && (q.size() != 0), stable_m, 1'b0};
            total_cnt++;
            if (got !== want) $display("FAIL random cyc %0d: data/oe/irq/stable got %h, expected %h", c, got, want);
            else pass_cnt++;
            tick();
        end
        rst = 0;
        clear_strobes();
    endtask

    initial begin
        clear_strobes();
        test_reset();
        test_basic_commit();
        test_glitch();
        test_overflow();
        test_full_commit_pop();
        test_both_strobes();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
